// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 receiver types and constants
package ps2_pkg;

  typedef enum logic [1:0] {
    PS2_IDLE   = 2'd0,
    PS2_DATA   = 2'd1,
    PS2_PARITY = 2'd2,
    PS2_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-FF synchronizer plus counting glitch filter for one PS/2 line
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic       sync_q1;
  logic       sync_q2;
  logic [7:0] run_cnt;

  // Lines idle high, so every stage resets to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      dout    <= 1'b1;
      run_cnt <= 8'd0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
      if (sync_q2 == dout) begin
        run_cnt <= 8'd0;
      end else if (run_cnt == 8'(FILTER_LEN - 1)) begin
        dout    <= sync_q2;
        run_cnt <= 8'd0;
      end else begin
        run_cnt <= run_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/ps2_frame_receiver.sv
// rtl/ps2_frame_receiver.sv - PS/2 device-to-host frame decoder with two-byte keycode history
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kclk,
  input  logic        kdata,
  output logic [15:0] keycode,
  output logic        oflag,
  output logic        parity_err
);

  logic       kclk_f;
  logic       kdata_f;
  logic       kclk_q;
  logic       fall;
  ps2_state_e state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       parity_bit;
  logic [31:0] wd_cnt;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_kclk_filter (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (kclk),
    .dout (kclk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_kdata_filter (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (kdata),
    .dout (kdata_f)
  );

  assign fall = kclk_q & ~kclk_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kclk_q     <= 1'b1;
      state      <= PS2_IDLE;
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'd0;
      parity_bit <= 1'b0;
      wd_cnt     <= 32'd0;
      keycode    <= 16'h0000;
      oflag      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      kclk_q     <= kclk_f;
      oflag      <= 1'b0;
      parity_err <= 1'b0;
      // A fall always takes priority over the watchdog so a late-but-valid edge is kept.
      if (fall) begin
        wd_cnt <= 32'd0;
        case (state)
          PS2_IDLE: begin
            if (!kdata_f) begin
              state   <= PS2_DATA;
              bit_cnt <= 3'd0;
            end
          end
          PS2_DATA: begin
            shift_reg <= {kdata_f, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PS2_PARITY;
          end
          PS2_PARITY: begin
            parity_bit <= kdata_f;
            state      <= PS2_STOP;
          end
          default: begin
            if (kdata_f && ((^shift_reg) ^ parity_bit)) begin
              keycode <= {keycode[7:0], shift_reg};
              oflag   <= 1'b1;
            end else begin
              parity_err <= 1'b1;
            end
            state <= PS2_IDLE;
          end
        endcase
      end else if (state != PS2_IDLE) begin
        if (wd_cnt == 32'(TIMEOUT_CYC)) begin
          state  <= PS2_IDLE;
          wd_cnt <= 32'd0;
        end else begin
          wd_cnt <= wd_cnt + 32'd1;
        end
      end else begin
        wd_cnt <= 32'd0;
      end
    end
  end

endmodule
